// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: buffers one N-point complex symbol in a ping-pong RAM and
// replays its last cp_len samples ahead of the full symbol, with valid/ready on both sides.
module ofdm_cp_insert #(
    parameter int DW       = 16,
    parameter int N        = 64,
    parameter int LOG2N    = 6,
    parameter int CP_LONG  = 16,
    parameter int CP_SHORT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cp_sel,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic          i_in_sof,
    input  logic [DW-1:0] i_in_re,
    input  logic [DW-1:0] i_in_im,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_out_sof,
    output logic          o_out_eof,
    output logic          o_out_is_cp,
    output logic [DW-1:0] o_out_re,
    output logic [DW-1:0] o_out_im,
    output logic          o_sync_err
);

    typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

    localparam logic [LOG2N-1:0] LAST      = LOG2N'(N - 1);
    localparam logic [LOG2N:0]   CPL_LONG  = (LOG2N + 1)'(CP_LONG);
    localparam logic [LOG2N:0]   CPL_SHORT = (LOG2N + 1)'(CP_SHORT);

    // First prefix index; a zero-length prefix wraps to index 0, the body start.
    function automatic logic [LOG2N-1:0] cp_start_addr(input logic [LOG2N:0] len);
        logic [LOG2N:0] s;
        s = (LOG2N + 1)'(N) - len;
        return s[LOG2N-1:0];
    endfunction

    logic signed [DW-1:0] r_mem_re [0:2*N-1];
    logic signed [DW-1:0] r_mem_im [0:2*N-1];

    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             r_out_bank;
    logic [LOG2N-1:0] r_wr_cnt;
    logic [LOG2N-1:0] r_rd_addr;
    logic [LOG2N:0]   r_cp_len [0:1];
    state_t           r_state;
    logic             r_first;
    logic             r_in_ready;
    logic             r_sync_err;
    logic             r_out_valid;
    logic             r_out_sof;
    logic             r_out_eof;
    logic             r_out_is_cp;
    logic signed [DW-1:0] r_out_re;
    logic signed [DW-1:0] r_out_im;

    logic             w_accept;
    logic             w_resync;
    logic             w_wr_done;
    logic             w_load;
    logic             w_release;
    logic [LOG2N-1:0] w_wr_addr;
    logic [1:0]       w_full_nxt;
    logic             w_wr_bank_nxt;
    logic signed [DW-1:0] w_rd_re;
    logic signed [DW-1:0] w_rd_im;

    assign w_accept  = i_in_valid & r_in_ready;
    assign w_resync  = w_accept & i_in_sof & (r_wr_cnt != '0);
    assign w_wr_done = w_accept & ~w_resync & (r_wr_cnt == LAST);
    assign w_wr_addr = w_resync ? '0 : r_wr_cnt;
    assign w_load    = ~r_out_valid | i_out_ready;
    // A bank is handed back once its final body sample has left the output register.
    assign w_release = r_out_valid & r_out_eof & i_out_ready;

    assign w_rd_re = r_mem_re[{r_rd_bank, r_rd_addr}];
    assign w_rd_im = r_mem_im[{r_rd_bank, r_rd_addr}];

    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[r_out_bank] = 1'b0;
        if (w_wr_done) w_full_nxt[r_wr_bank]  = 1'b1;
        w_wr_bank_nxt = r_wr_bank ^ w_wr_done;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_re[{r_wr_bank, w_wr_addr}] <= $signed(i_in_re);
            r_mem_im[{r_wr_bank, w_wr_addr}] <= $signed(i_in_im);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_out_bank  <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_addr   <= '0;
            r_cp_len[0] <= '0;
            r_cp_len[1] <= '0;
            r_state     <= IDLE;
            r_first     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_sync_err  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_is_cp <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            // Write side
            r_full     <= w_full_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_in_ready <= ~w_full_nxt[w_wr_bank_nxt];
            r_sync_err <= w_resync;
            if (w_accept) r_wr_cnt <= w_resync ? LOG2N'(1) : r_wr_cnt + 1'b1;
            if (w_wr_done) r_cp_len[r_wr_bank] <= i_cp_sel ? CPL_SHORT : CPL_LONG;

            // Read side
            case (r_state)
                IDLE: begin
                    if (w_load) r_out_valid <= 1'b0;
                    if (r_full[r_rd_bank]) begin
                        r_state   <= (r_cp_len[r_rd_bank] != '0) ? CP : BODY;
                        r_rd_addr <= cp_start_addr(r_cp_len[r_rd_bank]);
                        r_first   <= 1'b1;
                    end
                end
                default: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_re    <= w_rd_re;
                        r_out_im    <= w_rd_im;
                        r_out_sof   <= r_first;
                        r_out_is_cp <= (r_state == CP);
                        r_out_eof   <= (r_state == BODY) && (r_rd_addr == LAST);
                        r_out_bank  <= r_rd_bank;
                        r_first     <= 1'b0;
                        if (r_rd_addr != LAST) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end else if (r_state == CP) begin
                            r_state   <= BODY;
                            r_rd_addr <= '0;
                        end else begin
                            // Chain straight into the other bank when it is ready, avoiding a bubble.
                            r_rd_bank <= ~r_rd_bank;
                            if (r_full[~r_rd_bank]) begin
                                r_state   <= (r_cp_len[~r_rd_bank] != '0) ? CP : BODY;
                                r_rd_addr <= cp_start_addr(r_cp_len[~r_rd_bank]);
                                r_first   <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_sync_err  = r_sync_err;
    assign o_out_valid = r_out_valid;
    assign o_out_sof   = r_out_sof;
    assign o_out_eof   = r_out_eof;
    assign o_out_is_cp = r_out_is_cp;
    assign o_out_re    = r_out_re;
    assign o_out_im    = r_out_im;

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Directed bench for ofdm_cp_insert: a small write-side model pushes expected CP+body
// samples into a scoreboard queue, and the output handshake pops and compares them.
module tb_ofdm_cp_insert;

    localparam int DW       = 16;
    localparam int N        = 64;
    localparam int LOG2N    = 6;
    localparam int CP_LONG  = 16;
    localparam int CP_SHORT = 8;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sof;
        logic          eof;
        logic          cp;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cp_sel;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eof;
    logic          out_is_cp;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          sync_err;

    ofdm_cp_insert #(
        .DW(DW), .N(N), .LOG2N(LOG2N), .CP_LONG(CP_LONG), .CP_SHORT(CP_SHORT)
    ) dut (
        .clk(clk), .reset(reset), .i_cp_sel(cp_sel),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_sof(in_sof),
        .i_in_re(in_re), .i_in_im(in_im),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_sof(out_sof), .o_out_eof(out_eof), .o_out_is_cp(out_is_cp),
        .o_out_re(out_re), .o_out_im(out_im), .o_sync_err(sync_err)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] m_re [N];
    logic [DW-1:0] m_im [N];
    int            m_wcnt = 0;
    logic          exp_sync = 1'b0;
    int            last_done_edge = 0;
    int            last_rise_edge = 0;
    logic          prev_valid = 1'b0;
    int            run = 0;
    int            last_run = 0;
    bit            saw_inrdy_low = 0;
    int            n_sync_pulses = 0;
    int            n_popped = 0;
    bit            held = 0;
    logic [2*DW+3:0] snap = '0;
    bit            rand_rdy = 0;
    bit            acc_flag = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept();
        int   cpl;
        exp_t e;
        acc_flag = 1;
        if (in_sof && m_wcnt != 0) begin
            m_wcnt   = 0;
            exp_sync = 1'b1;
        end
        m_re[m_wcnt] = in_re;
        m_im[m_wcnt] = in_im;
        m_wcnt++;
        if (m_wcnt == N) begin
            cpl = cp_sel ? CP_SHORT : CP_LONG;
            for (int i = N - cpl; i < N; i++) begin
                e = {m_re[i], m_im[i], (i == N - cpl), 1'b0, 1'b1};
                exp_q.push_back(e);
            end
            for (int i = 0; i < N; i++) begin
                e = {m_re[i], m_im[i], (cpl == 0 && i == 0), (i == N - 1), 1'b0};
                exp_q.push_back(e);
            end
            m_wcnt         = 0;
            last_done_edge = cyc;
        end
    endtask

    // One clock: observe and check at the falling edge, then return just after the rising edge.
    task automatic step();
        logic [2*DW+3:0] cur;
        exp_t            e;
        @(negedge clk);
        cyc++;
        cur = {out_valid, out_re, out_im, out_sof, out_eof, out_is_cp};
        if (held) chk("hold_stable", 64'(cur), 64'(snap));
        held = out_valid & ~out_ready;
        snap = cur;
        chk("sync_err", 64'(sync_err), 64'(exp_sync));
        if (sync_err) n_sync_pulses++;
        exp_sync = 1'b0;
        if (out_valid && !prev_valid) last_rise_edge = cyc - 1;
        if (out_valid) run++;
        else if (run > 0) begin
            last_run = run;
            run      = 0;
        end
        prev_valid = out_valid;
        if (!in_ready && !reset) saw_inrdy_low = 1;
        if (out_valid && out_ready) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_errors++;
                $error("FAIL out_unexpected: observed re=0x%0h with no sample expected", out_re);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_sample", 64'({out_re, out_im, out_sof, out_eof, out_is_cp}), 64'(e));
                n_popped++;
            end
        end
        if (in_valid && in_ready) model_accept();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_sample(input int v, input logic sof);
        int t = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_re    = DW'(v);
        in_im    = DW'(-v);
        acc_flag = 0;
        while (!acc_flag && t < 400) begin
            step();
            t++;
        end
        n_checks++;
        assert (acc_flag) else begin
            n_errors++;
            $error("FAIL accept_timeout: observed no accept after %0d cycles expected accept", t);
        end
    endtask

    task automatic send_symbol(input int base, input logic sel_a, input logic sel_b, input int sw_at);
        for (int k = 0; k < N; k++) begin
            cp_sel = (k < sw_at) ? sel_a : sel_b;
            send_sample(base + k, (k == 0));
        end
    endtask

    task automatic drain(input int lim);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < lim) begin
            step();
            t++;
        end
        step();
        n_checks++;
        assert (t < lim) else begin
            n_errors++;
            $error("FAIL drain_timeout: observed %0d pending samples expected 0", exp_q.size());
        end
    endtask

    initial begin
        int t;
        reset     = 1'b1;
        cp_sel    = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("reset_outputs",
            64'({in_ready, out_valid, out_sof, out_eof, out_is_cp, out_re, out_im, sync_err}), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("in_ready_before_edge", 64'(in_ready), 64'(0));
        step();
        chk("in_ready_after_release", 64'(in_ready), 64'(1));

        // Single symbol, long CP, latency
        saw_inrdy_low = 0;
        send_symbol(0, 1'b0, 1'b0, N);
        in_valid = 1'b0;
        drain(400);
        chk("latency_edges", 64'(last_rise_edge - last_done_edge), 64'(2));
        chk("single_run_len", 64'(last_run), 64'(N + CP_LONG));
        chk("in_ready_stayed_high", 64'(saw_inrdy_low), 64'(0));

        // Short CP, then cp_sel flipped mid-symbol
        send_symbol(100, 1'b1, 1'b1, N);
        send_symbol(200, 1'b1, 1'b0, 32);
        in_valid = 1'b0;
        drain(600);

        // Four symbols streamed with no backpressure
        saw_inrdy_low = 0;
        for (int s = 0; s < 4; s++) send_symbol(300 + s * N, 1'b0, 1'b0, N);
        in_valid = 1'b0;
        drain(2000);
        chk("contiguous_run", 64'(last_run), 64'(4 * (N + CP_LONG)));
        chk("in_ready_throttled", 64'(saw_inrdy_low), 64'(1));

        // Same four symbols with random downstream ready
        rand_rdy = 1;
        for (int s = 0; s < 4; s++) send_symbol(300 + s * N, 1'b0, 1'b0, N);
        in_valid = 1'b0;
        drain(5000);
        rand_rdy  = 0;
        out_ready = 1'b1;
        step();

        // Resync: in_sof arrives after 20 samples
        n_sync_pulses = 0;
        cp_sel = 1'b0;
        for (int k = 0; k < 20; k++) send_sample(500 + k, (k == 0));
        send_symbol(600, 1'b0, 1'b0, N);
        in_valid = 1'b0;
        drain(600);
        chk("sync_pulse_count", 64'(n_sync_pulses), 64'(1));

        // Asynchronous reset in the middle of output
        n_popped = 0;
        send_symbol(700, 1'b0, 1'b0, N);
        in_valid = 1'b0;
        t = 0;
        while (n_popped < 30 && t < 400) begin
            step();
            t++;
        end
        chk("popped_before_reset", 64'(n_popped), 64'(30));
        reset = 1'b1;
        #1;
        chk("reset_async_valid", 64'(out_valid), 64'(0));
        chk("reset_async_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        m_wcnt   = 0;
        exp_sync = 1'b0;
        held     = 0;
        step();
        step();
        reset = 1'b0;
        chk("in_ready_held_low", 64'(in_ready), 64'(0));
        step();
        chk("in_ready_rerelease", 64'(in_ready), 64'(1));
        repeat (10) step();
        chk("no_stale_output", 64'(out_valid), 64'(0));
        send_symbol(800, 1'b0, 1'b0, N);
        in_valid = 1'b0;
        drain(600);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
